dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-ported data memory (combinational read, posedge write).
- Port 0 serves the CPU load/store path; port 1 serves the program/data loader and debug reader.
- Grants one request at a time, using round-robin on contention.
- Drives the memory for exactly one cycle per access, returns registered read data with a one-cycle ack, and rejects misaligned or out-of-range addresses.

---
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for dmem_arbiter.
// The arbiter connects through the slave modport; requesters/memory model use master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              err0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic              err1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_writeData;
  logic              mem_writeEnable;
  logic [DATA_W-1:0] mem_read;

  logic              busy;
  logic              owner;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_read,
    output ack0, rdata0, err0,
    output ack1, rdata1, err1,
    output mem_addr, mem_writeData, mem_writeEnable,
    output busy, owner
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_read,
    input  ack0, rdata0, err0,
    input  ack1, rdata1, err1,
    input  mem_addr, mem_writeData, mem_writeEnable,
    input  busy, owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-ported data memory.
// One access per IDLE -> ACCESS -> RESP pass; misaligned/out-of-range accesses are rejected.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 32
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              err0_q, err0_d, err1_q, err1_d;

  logic              bad;
  logic              grant1;
  logic              ack0, ack1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] access_rdata;

  // Extra index bit keeps the range check correct even when DEPTH_WORDS == 2**IDX_W.
  assign bad = (addr_q[1:0] != 2'b00) ||
               ({1'b0, addr_q[ADDR_W-1:2]} >= (IDX_W + 1)'(DEPTH_WORDS));
  assign access_rdata = (we_q || bad) ? '0 : bus.mem_read;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err0_d    = err0_q;
    err1_d    = err1_q;
    grant1    = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On contention the port that was not served last wins.
          grant1  = bus.req1 && (!bus.req0 || !last_q);
          owner_d = grant1;
          addr_d  = grant1 ? bus.addr1  : bus.addr0;
          wdata_d = grant1 ? bus.wdata1 : bus.wdata0;
          we_d    = grant1 ? bus.we1    : bus.we0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = we_q && !bad && !reset;
        last_d    = owner_q;
        if (owner_q) begin
          rdata1_d = access_rdata;
          err1_d   = bad;
        end else begin
          rdata0_d = access_rdata;
          err0_d   = bad;
        end
        state_d = RESP;
      end
      RESP: begin
        ack0    = !owner_q;
        ack1    = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign bus.ack0            = ack0;
  assign bus.ack1            = ack1;
  assign bus.rdata0          = rdata0_q;
  assign bus.rdata1          = rdata1_q;
  assign bus.err0            = err0_q;
  assign bus.err1            = err1_q;
  assign bus.mem_addr        = mem_addr;
  assign bus.mem_writeData   = mem_wdata;
  assign bus.mem_writeEnable = mem_we;
  assign bus.busy            = (state_q != IDLE);
  assign bus.owner           = owner_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: transaction-level reference model with a shadow memory,
// plus directed scenarios for reset, contention, bad addresses and reset during an access.
module tb_dmem_arbiter;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk;
  logic reset;
  logic init_mem;
  logic [31:0] mem [DEPTH];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, posedge write; poison value outside the implemented range.
  always_comb begin
    if ((bus.mem_addr >> 2) < 32'(DEPTH)) bus.mem_read = mem[bus.mem_addr[6:2]];
    else                                   bus.mem_read = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i + 7);
    end else if (bus.mem_writeEnable && ((bus.mem_addr >> 2) < 32'(DEPTH))) begin
      mem[bus.mem_addr[6:2]] <= bus.mem_writeData;
    end
  end

  // Reference model state
  int unsigned n_checks;
  int unsigned n_fail;
  int          cyc;
  int          g;
  bit          infl;
  bit          cp;
  bit          last_m;
  txn_t        cur;
  bit          pend [2];
  txn_t        ptx [2];
  logic [31:0] exp_rdata [2];
  logic        exp_err [2];
  logic [31:0] ref_mem [DEPTH];
  int          mode;
  bit          rst_now;
  bit          rst_in_access;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    if (r == 1) return 32'($urandom_range(DEPTH, DEPTH + 100) * 4);
    if (r < 6)  return 32'($urandom_range(0, 7) * 4);
    return 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = rand_addr();
    t.wdata = $urandom();
    return t;
  endfunction

  task automatic issue(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    pend[p]      = 1'b1;
    ptx[p].we    = we;
    ptx[p].addr  = addr;
    ptx[p].wdata = wdata;
  endtask

  task automatic drive();
    bus.req0   = pend[0];
    bus.we0    = ptx[0].we;
    bus.addr0  = ptx[0].addr;
    bus.wdata0 = ptx[0].wdata;
    bus.req1   = pend[1];
    bus.we1    = ptx[1].we;
    bus.addr1  = ptx[1].addr;
    bus.wdata1 = ptx[1].wdata;
  endtask

  // One cycle: check outputs seen in this cycle, then advance requesters and the model.
  task automatic step();
    bit was_idle;
    bit acc;
    bit rsp;
    @(negedge clk);
    cyc++;
    was_idle = !infl;
    acc      = infl && (cyc == g + 1);
    rsp      = infl && (cyc == g + 2);
    if (rsp) begin
      exp_rdata[cp] = (cur.we || is_bad(cur.addr)) ? 32'h0 : ref_mem[int'(cur.addr / 4)];
      exp_err[cp]   = is_bad(cur.addr);
    end
    check_eq("busy", 32'(bus.busy), 32'(infl));
    if (infl) check_eq("owner", 32'(bus.owner), 32'(cp));
    check_eq("mem_addr", bus.mem_addr, acc ? cur.addr : 32'h0);
    check_eq("mem_wdata", bus.mem_writeData, acc ? cur.wdata : 32'h0);
    check_eq("mem_we", 32'(bus.mem_writeEnable), 32'(acc && cur.we && !is_bad(cur.addr)));
    check_eq("ack0", 32'(bus.ack0), 32'(rsp && cp == 1'b0));
    check_eq("ack1", 32'(bus.ack1), 32'(rsp && cp == 1'b1));
    check_eq("rdata0", bus.rdata0, exp_rdata[0]);
    check_eq("rdata1", bus.rdata1, exp_rdata[1]);
    check_eq("err0", 32'(bus.err0), 32'(exp_err[0]));
    check_eq("err1", 32'(bus.err1), 32'(exp_err[1]));

    if (rst_now || (rst_in_access && acc)) begin
      reset         = 1'b1;
      rst_now       = 1'b0;
      rst_in_access = 1'b0;
      infl          = 1'b0;
      last_m        = 1'b1;
      pend[0]       = 1'b0;
      pend[1]       = 1'b0;
      exp_rdata[0]  = 32'h0;
      exp_rdata[1]  = 32'h0;
      exp_err[0]    = 1'b0;
      exp_err[1]    = 1'b0;
      drive();
      return;
    end
    reset = 1'b0;

    if (rsp) begin
      if (cur.we && !is_bad(cur.addr)) ref_mem[int'(cur.addr / 4)] = cur.wdata;
      infl     = 1'b0;
      pend[cp] = 1'b0;
    end

    for (int p = 0; p < 2; p++) begin
      if (mode == 2 && !pend[p]) begin
        pend[p] = 1'b1;
        ptx[p]  = rand_txn();
      end else if (mode == 1) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          ptx[p]  = rand_txn();
        end else if (pend[p] && !(infl && int'(cp) == p) && $urandom_range(0, 7) == 0) begin
          ptx[p] = rand_txn();
        end
      end
    end
    drive();

    if (was_idle && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) cp = !last_m;
      else                    cp = pend[1];
      last_m = cp;
      cur    = ptx[cp];
      infl   = 1'b1;
      g      = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    g             = 0;
    infl          = 1'b0;
    cp            = 1'b0;
    last_m        = 1'b1;
    mode          = 0;
    rst_now       = 1'b0;
    rst_in_access = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p]      = 1'b0;
      ptx[p]       = '0;
      exp_rdata[p] = 32'h0;
      exp_err[p]   = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i + 7);
    init_mem = 1'b1;
    reset    = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    init_mem = 1'b0;

    step();                                    // reset state
    issue(0, 1'b0, 32'h0, 32'h0);              // read word 0 (7)
    run(5);
    issue(1, 1'b1, 32'h10, 32'h0000_00AB);     // write 0xAB, then read back on port 0
    run(5);
    issue(0, 1'b0, 32'h10, 32'h0);
    run(5);

    rst_now = 1'b1;                            // contention straight from reset
    step();
    mode = 2;
    run(12);
    mode = 0;
    run(8);

    issue(0, 1'b1, 32'h6, 32'h1234_5678);      // misaligned
    run(5);
    issue(0, 1'b1, 32'h80, 32'h8765_4321);     // index 32, out of range
    run(5);

    issue(1, 1'b1, 32'h4, 32'h0000_0055);      // reset lands in ACCESS
    rst_in_access = 1'b1;
    run(4);
    issue(0, 1'b0, 32'h4, 32'h0);              // word 1 still 8
    run(5);

    issue(0, 1'b0, 32'h8, 32'h0);              // rdata0 holds 9 across port 1 read
    run(5);
    issue(1, 1'b0, 32'hC, 32'h0);
    run(5);

    mode = 1;
    run(3000);
    mode = 0;
    run(12);
    check_eq("drain_pend0", 32'(pend[0]), 32'h0);
    check_eq("drain_pend1", 32'(pend[1]), 32'h0);

    for (int i = 0; i < DEPTH; i++) check_eq($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
